// File: rtl/batch_sample_reader.sv
// Read-side sequencer for the 4-segment sample ring buffer: three concurrent address sweeps per completed segment.
// Optional overrun flag is enabled by defining BATCH_READER_ERRCHK_EN; otherwise err is tied low.
module batch_sample_reader #(
  parameter int depth = 220,
  parameter int N     = 3,
  parameter int OSR   = 1,
  localparam int DSD  = (depth + OSR - 1) / OSR,
  localparam int AW   = $clog2(4 * DSD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  output logic [AW-1:0] addrOut1,
  output logic [AW-1:0] addrOut2,
  output logic [AW-1:0] addrOut3,
  output logic          rdValid,
  output logic          rdFirst,
  output logic          rdLast,
  output logic          err
);

  localparam logic [AW-1:0] LAST = AW'(DSD - 1);

  if (N < 1 || OSR < 1 || depth < 1) begin : g_bad_params
    $error("batch_sample_reader: depth, N and OSR must all be positive");
  end

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state_reg;
  logic [1:0]    seg_cnt_reg;
  logic [1:0]    w_reg;
  logic [AW-1:0] i_reg;

  logic [3:0]    seg_end;
  logic          complete;
  logic [1:0]    w_new;
  logic          start;
  logic          advance;
  logic [1:0]    w_next;
  logic [AW-1:0] i_next;
  logic [AW-1:0] addr1_next;
  logic [AW-1:0] addr2_next;
  logic [AW-1:0] addr3_next;

  function automatic logic [AW-1:0] seg_base(input logic [1:0] s);
    case (s)
      2'd0:    return '0;
      2'd1:    return AW'(DSD);
      2'd2:    return AW'(2 * DSD);
      default: return AW'(3 * DSD);
    endcase
  endfunction

  // Compare against the four fixed segment-end addresses instead of dividing by DSD.
  for (genvar gi = 0; gi < 4; gi++) begin : g_seg_end
    assign seg_end[gi] = wrEn && (wrAddr == AW'(gi * DSD + DSD - 1));
  end

  assign complete = |seg_end;

  always_comb begin
    w_new = '0;
    for (int k = 0; k < 4; k++) begin
      if (seg_end[k]) w_new = 2'(k);
    end
  end

  always_comb begin
    start   = 1'b0;
    advance = 1'b0;
    case (state_reg)
      IDLE:  start = complete && (seg_cnt_reg >= 2'd2);
      SWEEP: begin
        start   = complete;
        advance = !complete && (i_reg != LAST);
      end
      default: ;
    endcase
    w_next     = start ? w_new : w_reg;
    i_next     = start ? '0 : i_reg + AW'(1);
    addr1_next = seg_base(w_next + 2'd2) + i_next;
    addr2_next = seg_base(w_next) + (LAST - i_next);
    addr3_next = seg_base(w_next + 2'd3) + (LAST - i_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      seg_cnt_reg <= '0;
      w_reg       <= '0;
      i_reg       <= '0;
      addrOut1    <= '0;
      addrOut2    <= '0;
      addrOut3    <= '0;
      rdValid     <= 1'b0;
      rdFirst     <= 1'b0;
      rdLast      <= 1'b0;
    end else begin
      // Flags trail the addresses by one cycle to line up with the RAM read latency.
      rdValid <= (state_reg == SWEEP);
      rdFirst <= (state_reg == SWEEP) && (i_reg == '0);
      rdLast  <= (state_reg == SWEEP) && (i_reg == LAST);

      if (start || advance) begin
        w_reg    <= w_next;
        i_reg    <= i_next;
        addrOut1 <= addr1_next;
        addrOut2 <= addr2_next;
        addrOut3 <= addr3_next;
      end

      case (state_reg)
        IDLE: begin
          if (complete) begin
            seg_cnt_reg <= (seg_cnt_reg >= 2'd2) ? 2'd3 : seg_cnt_reg + 2'd1;
          end
          if (start) state_reg <= SWEEP;
        end
        SWEEP: begin
          if (!start && !advance) begin
            state_reg <= IDLE;
            i_reg     <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef BATCH_READER_ERRCHK_EN
  logic overrun;
  logic err_reg;

  assign overrun = (state_reg == SWEEP) && complete && (i_reg != LAST);

  always_ff @(posedge clk) begin
    if (rst)          err_reg <= 1'b0;
    else if (overrun) err_reg <= 1'b1;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_batch_sample_reader.sv
// Directed bench for batch_sample_reader with depth=8, OSR=1 (DSD=8, AW=5).
// Expected err level follows whether BATCH_READER_ERRCHK_EN is defined for the build.
module tb_batch_sample_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       wrEn;
  logic [4:0] wrAddr;
  logic [4:0] addrOut1, addrOut2, addrOut3;
  logic       rdValid, rdFirst, rdLast, err;

  int n_asserts = 0;
  int n_fail    = 0;

`ifdef BATCH_READER_ERRCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  batch_sample_reader #(.depth(8), .N(3), .OSR(1)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr),
    .addrOut1(addrOut1), .addrOut2(addrOut2), .addrOut3(addrOut3),
    .rdValid(rdValid), .rdFirst(rdFirst), .rdLast(rdLast), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input int a);
    wrEn   = en;
    wrAddr = 5'(a);
  endtask

  task automatic check_addr(input int a1, input int a2, input int a3);
    chk("addrOut1", 32'(addrOut1), 32'(a1));
    chk("addrOut2", 32'(addrOut2), 32'(a2));
    chk("addrOut3", 32'(addrOut3), 32'(a3));
    $display("t=%0t addr %0d %0d %0d (want %0d %0d %0d)", $time, addrOut1, addrOut2, addrOut3, a1, a2, a3);
  endtask

  task automatic check_flags(input logic v, input logic f, input logic l);
    chk("rdValid", 32'(rdValid), 32'(v));
    chk("rdFirst", 32'(rdFirst), 32'(f));
    chk("rdLast",  32'(rdLast),  32'(l));
  endtask

  // Called right after the edge that started a sweep at addresses (s1,s2,s3); runs the 8 following edges.
  task automatic sweep(input int s1, input int s2, input int s3, input logic wr, input int wstart);
    for (int k = 1; k <= 8; k++) begin
      drive(wr, (wstart + k - 1) % 32);
      tick();
      check_flags(1'b1, k == 1, k == 8);
      if (k < 8) check_addr(s1 + k, s2 - k, s3 - k);
    end
  endtask

  task automatic fill(input int from, input int upto);
    for (int a = from; a <= upto; a++) begin
      drive(1'b1, a);
      tick();
      chk("fill_no_valid", 32'(rdValid), 32'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0);
    repeat (5) tick();
    check_flags(1'b0, 1'b0, 1'b0);
    check_addr(0, 0, 0);
    chk("err_reset", 32'(err), 32'(0));
    rst = 1'b0;

    // Fill, then continuous stream with seamless restarts, then wrap-around.
    fill(0, 23);
    check_addr(0, 23, 15);
    sweep(0, 23, 15, 1'b1, 24);
    check_addr(8, 31, 23);
    sweep(8, 31, 23, 1'b1, 0);
    check_addr(16, 7, 31);
    sweep(16, 7, 31, 1'b0, 0);
    tick();
    check_flags(1'b0, 1'b0, 1'b0);
    check_addr(23, 0, 24);

    // Reset mid-sweep at i=4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fill(0, 23);
    check_addr(0, 23, 15);
    drive(1'b0, 0);
    repeat (4) tick();
    check_addr(4, 19, 11);
    rst = 1'b1;
    tick();
    check_flags(1'b0, 1'b0, 1'b0);
    check_addr(0, 0, 0);
    chk("err_midreset", 32'(err), 32'(0));
    rst = 1'b0;
    fill(0, 15);
    fill(16, 23);
    check_addr(0, 23, 15);

    // Overrun: segment-3 completion at i=3 restarts the sweep.
    drive(1'b0, 0);
    repeat (3) tick();
    check_addr(3, 20, 12);
    check_flags(1'b1, 1'b0, 1'b0);
    drive(1'b1, 31);
    tick();
    check_flags(1'b1, 1'b0, 1'b0);
    check_addr(8, 31, 23);
    chk("err_overrun", 32'(err), 32'(EXP_ERR));
    sweep(8, 31, 23, 1'b0, 0);
    tick();
    check_flags(1'b0, 1'b0, 1'b0);
    chk("err_sticky", 32'(err), 32'(EXP_ERR));

    // Write gaps: wrEn low every other cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", 32'(err), 32'(0));
    for (int a = 0; a <= 23; a++) begin
      drive(1'b1, a);
      tick();
      chk("gap_no_valid", 32'(rdValid), 32'(0));
      if (a < 23) begin
        drive(1'b0, 0);
        tick();
        chk("gap_idle_valid", 32'(rdValid), 32'(0));
      end
    end
    check_addr(0, 23, 15);
    sweep(0, 23, 15, 1'b0, 0);
    tick();
    check_flags(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
